// File: rtl/reg_apb_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// One transfer in flight at a time, with a wait-state timeout abort.
module reg_apb_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  RegClk,
  input  logic                  RegReset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [31:0]           req0_wdata,
  output logic                  rsp0_valid,
  output logic [31:0]           rsp0_rdata,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [31:0]           req1_wdata,
  output logic                  rsp1_valid,
  output logic [31:0]           rsp1_rdata,
  output logic                  rsp1_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam logic [4:0] TMO = 5'(TIMEOUT);

  state_t      state;
  logic        last;
  logic        gnt_id;
  logic [4:0]  wait_cnt;

  logic        any_req;
  logic        win;
  logic        do_grant;
  logic        tmo;
  logic        done;
  logic [31:0] cap_rdata;
  logic        cap_err;

  // Round-robin pick: on contention the side not granted last wins.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (req0_valid & req1_valid):  win = ~last;
      (req0_valid & ~req1_valid): win = 1'b0;
      (~req0_valid & req1_valid): win = 1'b1;
      default:                    win = 1'b0;
    endcase
  end

  // Grant strobe and ready pulses, same cycle as the IDLE acceptance.
  always_comb begin
    any_req    = req0_valid | req1_valid;
    do_grant   = (state == IDLE) & any_req & ~RegReset;
    req0_ready = do_grant & ~win;
    req1_ready = do_grant & win;
  end

  // Completion decode; PREADY beats a coincident timeout.
  always_comb begin
    tmo       = (wait_cnt == TMO) & ~PREADY;
    done      = PREADY | tmo;
    cap_rdata = (PREADY & ~PWRITE) ? PRDATA : 32'h0;
    cap_err   = PREADY ? PSLVERR : 1'b1;
  end

  assign busy = (state != IDLE);

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge RegClk or posedge RegReset) begin
    if (RegReset) begin
      state      <= IDLE;
      last       <= 1'b1;
      gnt_id     <= 1'b0;
      wait_cnt   <= 5'd0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= 32'h0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= 32'h0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= 32'h0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id   <= win;
            last     <= win;
            PADDR    <= win ? req1_addr : req0_addr;
            PWDATA   <= win ? req1_wdata : req0_wdata;
            PWRITE   <= win ? req1_write : req0_write;
            PSEL     <= 1'b1;
            PENABLE  <= 1'b0;
            wait_cnt <= 5'd0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= 5'd0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            if (gnt_id) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= cap_rdata;
              rsp1_err   <= cap_err;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= cap_rdata;
              rsp0_err   <= cap_err;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 5'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_apb_arbiter.sv
// Directed self-checking bench for reg_apb_arbiter.
// Includes a small APB slave with programmable wait states.
module tb_reg_apb_arbiter;

  logic        RegClk = 1'b0;
  logic        RegReset = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic        req0_write = 1'b0;
  logic [7:0]  req0_addr = 8'h0;
  logic [31:0] req0_wdata = 32'h0;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        rsp0_err;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic        req1_write = 1'b0;
  logic [7:0]  req1_addr = 8'h0;
  logic [31:0] req1_wdata = 32'h0;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        rsp1_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = 32'h0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;

  int          wait_n = 0;
  int          acc_cnt = 0;
  logic [31:0] slave_rdata = 32'h0;

  reg_apb_arbiter #(.ADDR_WIDTH(8), .TIMEOUT(16)) dut (
    .RegClk(RegClk), .RegReset(RegReset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .busy(busy)
  );

  always #5 RegClk = ~RegClk;

  // Slave: PREADY rises after wait_n ACCESS cycles; errors at 0x1C.
  always @(negedge RegClk) begin
    if (PSEL && PENABLE) begin
      PREADY  = (acc_cnt >= wait_n);
      PRDATA  = slave_rdata;
      PSLVERR = PREADY && (PADDR == 8'h1C);
      acc_cnt = acc_cnt + 1;
    end else begin
      acc_cnt = 0;
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
    end
  end

  // Drops the request after its grant, then counts cycles to the response.
  task automatic wait_rsp(output int id, output int ncyc,
                          output int nacc);
    id = -1; ncyc = -1; nacc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge RegClk);
      if (i == 1) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      if (PSEL && PENABLE) nacc++;
      if (rsp0_valid || rsp1_valid) begin
        id = rsp1_valid ? 1 : 0;
        ncyc = i;
        return;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge RegClk);
    RegReset = 1'b1;
    req0_valid = 1'b1;
    #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE, busy, req0_ready, req1_ready} !== 6'b0 ||
        PADDR !== 8'h0 || PWDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_apb: psel=%b pen=%b pwr=%b busy=%b rdy=%b%b paddr=%h pwdata=%h required all 0",
               PSEL, PENABLE, PWRITE, busy, req0_ready, req1_ready, PADDR, PWDATA);
    end
    checks++;
    if ({rsp0_valid, rsp0_err, rsp1_valid, rsp1_err} !== 4'b0 ||
        rsp0_rdata !== 32'h0 || rsp1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp: v0=%b e0=%b d0=%h v1=%b e1=%b d1=%h required all 0",
               rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata);
    end
    @(negedge RegClk);
    req0_valid = 1'b0;
    RegReset = 1'b0;
  endtask

  task automatic test_write;
    int id, nc, na;
    wait_n = 0;
    slave_rdata = 32'hDEADBEEF;
    @(negedge RegClk);
    req0_valid = 1'b1; req0_write = 1'b1;
    req0_addr = 8'h04; req0_wdata = 32'h0000_20AB;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_grant: rdy0=%b rdy1=%b required 1 0", req0_ready, req1_ready);
    end
    @(negedge RegClk);
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 8'h04 ||
        PWDATA !== 32'h0000_20AB) begin
      errors++;
      $display("FAIL wr_setup: sel/en/wr=%b%b%b addr=%h data=%h required 101 04 000020ab",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    @(negedge RegClk);
    #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b111 || PADDR !== 8'h04 ||
        PWDATA !== 32'h0000_20AB) begin
      errors++;
      $display("FAIL wr_access: sel/en/wr=%b%b%b addr=%h data=%h required 111 04 000020ab",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    @(negedge RegClk);
    #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_err !== 1'b0 ||
        rsp0_rdata !== 32'h0 || PSEL !== 1'b0 || PWRITE !== 1'b0 ||
        PADDR !== 8'h04 || PWDATA !== 32'h0000_20AB) begin
      errors++;
      $display("FAIL wr_resp: v0=%b v1=%b err=%b rdata=%h psel=%b pwr=%b addr=%h data=%h required 1 0 0 0 0 0 04 000020ab",
               rsp0_valid, rsp1_valid, rsp0_err, rsp0_rdata, PSEL, PWRITE, PADDR, PWDATA);
    end
    @(negedge RegClk);
    #1;
    checks++;
    if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_pulse_end: v0=%b busy=%b required 0 0", rsp0_valid, busy);
    end
    id = 0; nc = 0; na = 0;
  endtask

  task automatic test_read;
    int id, nc, na;
    wait_n = 0;
    slave_rdata = 32'h0000_005A;
    @(negedge RegClk);
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 8'h0C;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL rd_grant: rdy0=%b rdy1=%b required 0 1", req0_ready, req1_ready);
    end
    wait_rsp(id, nc, na);
    checks++;
    if (id !== 1 || nc !== 3 || na !== 1 || rsp1_rdata !== 32'h5A ||
        rsp1_err !== 1'b0) begin
      errors++;
      $display("FAIL rd_resp: id=%0d cyc=%0d acc=%0d rdata=%h err=%b required 1 3 1 0000005a 0",
               id, nc, na, rsp1_rdata, rsp1_err);
    end
    checks++;
    if (rsp0_rdata !== 32'h0 || rsp0_err !== 1'b0) begin
      errors++;
      $display("FAIL rd_hold0: rdata0=%h err0=%b required 0 0", rsp0_rdata, rsp0_err);
    end
  endtask

  task automatic test_contention;
    int g[$];
    int r[$];
    int gc[$];
    int done_at;
    wait_n = 0;
    slave_rdata = 32'h1;
    @(negedge RegClk);
    RegReset = 1'b1;
    @(negedge RegClk);
    RegReset = 1'b0;
    req0_write = 1'b0; req1_write = 1'b0;
    req0_addr = 8'h30; req1_addr = 8'h34;
    req0_valid = 1'b1; req1_valid = 1'b1;
    done_at = -1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge RegClk);
      if (g.size() == 4) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      #1;
      if (req0_ready) begin g.push_back(0); gc.push_back(c); end
      if (req1_ready) begin g.push_back(1); gc.push_back(c); end
      if (rsp0_valid) r.push_back(0);
      if (rsp1_valid) r.push_back(1);
      if (g.size() >= 4 && r.size() >= 4) begin
        done_at = c;
        break;
      end
    end
    checks++;
    if (done_at < 0 || g.size() != 4 || r.size() != 4) begin
      errors++;
      $display("FAIL cont_count: grants=%0d rsps=%0d required 4 4", g.size(), r.size());
    end else begin
      checks++;
      if (g[0] != 0 || g[1] != 1 || g[2] != 0 || g[3] != 1 ||
          r[0] != 0 || r[1] != 1 || r[2] != 0 || r[3] != 1) begin
        errors++;
        $display("FAIL cont_order: g=%0d%0d%0d%0d r=%0d%0d%0d%0d required 0101 0101",
                 g[0], g[1], g[2], g[3], r[0], r[1], r[2], r[3]);
      end
      checks++;
      if (gc[1] - gc[0] != 4 || gc[2] - gc[1] != 4 || gc[3] - gc[2] != 4) begin
        errors++;
        $display("FAIL cont_b2b: gaps=%0d %0d %0d required 4 4 4",
                 gc[1] - gc[0], gc[2] - gc[1], gc[3] - gc[2]);
      end
    end
    @(negedge RegClk);
    @(negedge RegClk);
  endtask

  task automatic test_wait;
    int id, nc, na;
    wait_n = 3;
    slave_rdata = 32'h0000_1234;
    @(negedge RegClk);
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 8'h10;
    #1;
    wait_rsp(id, nc, na);
    checks++;
    if (id !== 0 || nc !== 6 || na !== 4 || rsp0_rdata !== 32'h1234 ||
        rsp0_err !== 1'b0) begin
      errors++;
      $display("FAIL wait3: id=%0d cyc=%0d acc=%0d rdata=%h err=%b required 0 6 4 00001234 0",
               id, nc, na, rsp0_rdata, rsp0_err);
    end
  endtask

  task automatic test_timeout;
    int id, nc, na;
    wait_n = 255;
    slave_rdata = 32'h7777_7777;
    @(negedge RegClk);
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 8'h20;
    #1;
    wait_rsp(id, nc, na);
    checks++;
    if (id !== 1 || nc !== 19 || na !== 17 || rsp1_rdata !== 32'h0 ||
        rsp1_err !== 1'b1 || PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      errors++;
      $display("FAIL timeout: id=%0d cyc=%0d acc=%0d rdata=%h err=%b psel=%b pen=%b required 1 19 17 0 1 0 0",
               id, nc, na, rsp1_rdata, rsp1_err, PSEL, PENABLE);
    end
    wait_n = 16;
    slave_rdata = 32'hCAFE_0001;
    @(negedge RegClk);
    req1_valid = 1'b1; req1_addr = 8'h24;
    #1;
    wait_rsp(id, nc, na);
    checks++;
    if (id !== 1 || nc !== 19 || rsp1_rdata !== 32'hCAFE_0001 ||
        rsp1_err !== 1'b0) begin
      errors++;
      $display("FAIL ready_wins: id=%0d cyc=%0d rdata=%h err=%b required 1 19 cafe0001 0",
               id, nc, rsp1_rdata, rsp1_err);
    end
  endtask

  task automatic test_slverr;
    int id, nc, na;
    wait_n = 0;
    slave_rdata = 32'h0000_00EE;
    @(negedge RegClk);
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 8'h1C;
    #1;
    wait_rsp(id, nc, na);
    checks++;
    if (id !== 0 || nc !== 3 || rsp0_err !== 1'b1 || rsp0_rdata !== 32'hEE) begin
      errors++;
      $display("FAIL slverr: id=%0d cyc=%0d err=%b rdata=%h required 0 3 1 000000ee",
               id, nc, rsp0_err, rsp0_rdata);
    end
  endtask

  task automatic test_reset_midxfer;
    int seen;
    wait_n = 255;
    @(negedge RegClk);
    req0_valid = 1'b1; req0_write = 1'b1;
    req0_addr = 8'h40; req0_wdata = 32'h55;
    @(negedge RegClk);
    req0_valid = 1'b0;
    @(negedge RegClk);
    @(negedge RegClk);
    #1;
    checks++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: psel=%b pen=%b required 1 1", PSEL, PENABLE);
    end
    RegReset = 1'b1;
    #1;
    checks++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || busy !== 1'b0 ||
        PWRITE !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: psel=%b pen=%b busy=%b pwr=%b required 0 0 0 0",
               PSEL, PENABLE, busy, PWRITE);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge RegClk);
      if (i == 1) RegReset = 1'b0;
      #1;
      if (rsp0_valid || rsp1_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_norsp: pulses=%0d required 0", seen);
    end
    @(negedge RegClk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ptr: rdy0=%b rdy1=%b required 1 0", req0_ready, req1_ready);
    end
    @(negedge RegClk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    RegReset = 1'b1;
    @(negedge RegClk);
    RegReset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_wait();
    test_timeout();
    test_slverr();
    test_reset_midxfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
